// File: rtl/drv_segment_pkg.sv
// Shared constants, state encoding and segment decode for the multiplexed
// decimal 7-segment driver.
package drv_segment_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Bit n drives segment n: 0 top, 1 upper-right, 2 lower-right, 3 bottom,
    // 4 lower-left, 5 upper-left, 6 middle.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nib <= 4'd9) begin
            seg = SEG_DIGIT[nib];
        end
        return seg;
    endfunction

endpackage

// File: rtl/drv_segment_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with detection of results that do not fit in p_width decimal digits.
module drv_segment_bin2bcd
    import drv_segment_pkg::*;
#(
    parameter int p_width     = 4,
    parameter int p_bin_width = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_bin_width-1:0] i_value,
    input  logic                   i_load,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [p_width*4-1:0]   o_bcd,
    output logic                   o_ovf
);

    localparam int NIB = p_width + 1;
    localparam int SW  = NIB * 4;
    localparam int CW  = $clog2(p_bin_width + 1);

    conv_state_t state_reg, state_next;

    logic [p_bin_width-1:0] bin_reg;
    logic [SW-1:0]          bcd_reg;
    logic [SW-1:0]          bcd_adj;
    logic                   sticky_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   done_reg;
    logic                   ovf_reg;
    logic [p_width*4-1:0]   out_reg;
    logic                   scratch_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // A carry lost off the top nibble means the value already exceeded the
    // scratch range, so it is remembered even if the top nibble later reads 0.
    assign scratch_ovf = sticky_reg | (bcd_reg[SW-1 -: 4] != 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_load) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(p_bin_width - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_reg != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_reg    <= '0;
            bcd_reg    <= '0;
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            out_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_load) begin
                        bin_reg    <= i_value;
                        bcd_reg    <= '0;
                        sticky_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    bcd_reg    <= {bcd_adj[SW-2:0], bin_reg[p_bin_width-1]};
                    bin_reg    <= bin_reg << 1;
                    sticky_reg <= sticky_reg | bcd_adj[SW-1];
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                COMMIT: begin
                    done_reg <= 1'b1;
                    ovf_reg  <= scratch_ovf;
                    if (!scratch_ovf) begin
                        out_reg <= bcd_reg[p_width*4-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_done = done_reg;
    assign o_bcd  = out_reg;
    assign o_ovf  = ovf_reg;

endmodule

// File: rtl/drv_segment_dec_scan.sv
// Multiplexed decimal 7-segment driver: converts a loaded binary value to BCD
// and scans the digits on a shared segment bus with optional zero blanking.
module drv_segment_dec_scan
    import drv_segment_pkg::*;
#(
    parameter int p_width     = 4,
    parameter int p_bin_width = 14,
    parameter int p_div       = 50000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_bin_width-1:0] i_value,
    input  logic                   i_load,
    input  logic                   i_blank_en,
    output logic                   o_busy,
    output logic                   o_ovf,
    output logic [6:0]             o_drv_sgmnt,
    output logic [p_width-1:0]     o_drv_digit
);

    localparam int DW = (p_div > 1) ? $clog2(p_div) : 1;
    localparam int IW = (p_width > 1) ? $clog2(p_width) : 1;

    logic [DW-1:0]        pre_reg;
    logic [IW-1:0]        idx_reg;
    logic [p_width*4-1:0] disp_bcd_reg;
    logic                 disp_ovf_reg;
    logic                 conv_done;
    logic                 conv_ovf;
    logic [p_width*4-1:0] conv_bcd;
    logic [p_width-1:0]   nib_zero;
    logic [3:0]           cur_nib;
    logic                 cur_blank;
    logic [6:0]           seg_next;
    logic [p_width-1:0]   digit_next;
    logic [6:0]           seg_reg;
    logic [p_width-1:0]   digit_reg;

    drv_segment_bin2bcd #(
        .p_width     (p_width),
        .p_bin_width (p_bin_width)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_value (i_value),
        .i_load  (i_load),
        .o_busy  (o_busy),
        .o_done  (conv_done),
        .o_bcd   (conv_bcd),
        .o_ovf   (conv_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else if (pre_reg == DW'(p_div - 1)) begin
            pre_reg <= '0;
            if (idx_reg == IW'(p_width - 1)) begin
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + IW'(1);
            end
        end else begin
            pre_reg <= pre_reg + DW'(1);
        end
    end

    // An overflowing result keeps the last good digits but shows dashes
    // until an in-range value commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            disp_bcd_reg <= '0;
            disp_ovf_reg <= 1'b0;
        end else if (conv_done) begin
            disp_ovf_reg <= conv_ovf;
            if (!conv_ovf) begin
                disp_bcd_reg <= conv_bcd;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < p_width; gi++) begin : g_zero
            assign nib_zero[gi] = (disp_bcd_reg[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    // Digit i>0 is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_nib    = '0;
        cur_blank  = 1'b0;
        digit_next = '0;
        for (int i = 0; i < p_width; i++) begin
            if (idx_reg == IW'(i)) begin
                cur_nib       = disp_bcd_reg[i*4 +: 4];
                digit_next[i] = 1'b1;
                cur_blank     = (i != 0);
                for (int j = i; j < p_width; j++) begin
                    cur_blank = cur_blank && nib_zero[j];
                end
            end
        end
    end

    always_comb begin
        seg_next = seg_decode(cur_nib);
        if (disp_ovf_reg) begin
            seg_next = SEG_DASH;
        end else if (i_blank_en && cur_blank) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seg_reg   <= '0;
            digit_reg <= '0;
        end else begin
            seg_reg   <= seg_next;
            digit_reg <= digit_next;
        end
    end

    assign o_drv_sgmnt = seg_reg;
    assign o_drv_digit = digit_reg;
    assign o_ovf       = disp_ovf_reg;

endmodule

// File: tb/tb_drv_segment_dec_scan.sv
// Self-checking bench: a 4-digit scanned instance plus a 1-digit,
// undivided instance; loaded values are scoreboarded against the scan output.
module tb_drv_segment_dec_scan;

    localparam int W   = 4;
    localparam int BW  = 14;
    localparam int DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst     = 1'b1;
    logic          load_a  = 1'b0;
    logic [BW-1:0] value_a = '0;
    logic          blank_a = 1'b0;
    logic          busy_a, ovf_a;
    logic [6:0]    sg_a;
    logic [W-1:0]  dg_a;

    logic          load_b  = 1'b0;
    logic [3:0]    value_b = '0;
    logic          blank_b = 1'b0;
    logic          busy_b, ovf_b;
    logic [6:0]    sg_b;
    logic [0:0]    dg_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];
    logic [6:0]   obs_seg [W];
    logic [W-1:0] obs_dig [W];

    drv_segment_dec_scan #(.p_width(W), .p_bin_width(BW), .p_div(DIV)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_value(value_a), .i_load(load_a),
        .i_blank_en(blank_a), .o_busy(busy_a), .o_ovf(ovf_a),
        .o_drv_sgmnt(sg_a), .o_drv_digit(dg_a)
    );

    drv_segment_dec_scan #(.p_width(1), .p_bin_width(4), .p_div(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_value(value_b), .i_load(load_b),
        .i_blank_en(blank_b), .o_busy(busy_b), .o_ovf(ovf_b),
        .o_drv_sgmnt(sg_b), .o_drv_digit(dg_b)
    );

    // Cycles since reset release; the scan phase of dut_a follows from it.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] exp_seg(input int v, input int d, input logic bl);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (v > 9999) return 7'h40;
        if (bl && d > 0 && v < p) return 7'h00;
        return SEG_TAB[(v / p) % 10];
    endfunction

    function automatic logic [6:0] exp_seg_b(input int v);
        if (v > 9) return 7'h40;
        return SEG_TAB[v];
    endfunction

    task automatic start_load(input int v, input bit push);
        @(negedge clk);
        value_a = BW'(v);
        load_a  = 1'b1;
        if (push) exp_q.push_back(v);
        @(posedge clk);
        #1;
        load_a = 1'b0;
    endtask

    // n = negedges seen with busy high before it dropped, -1 on timeout.
    task automatic wait_idle(output int n);
        n = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_a) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic capture_scan();
        int idx;
        repeat (2) @(negedge clk);
        for (int k = 0; k < W * DIV; k++) begin
            @(negedge clk);
            idx = ((cyc - 1) / DIV) % W;
            obs_seg[idx] = sg_a;
            obs_dig[idx] = dg_a;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_a, ovf_a, sg_a, dg_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b ovf=%b seg=%h dig=%b expected all 0", busy_a, ovf_a, sg_a, dg_a);
        end
        checks++;
        if ({busy_b, ovf_b, sg_b, dg_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b ovf=%b seg=%h dig=%b expected all 0", busy_b, ovf_b, sg_b, dg_b);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dg_a !== 4'b0001) begin
            errors++;
            $display("FAIL first_digit: got %b expected 0001", dg_a);
        end
        checks++;
        if (sg_a !== 7'h3F) begin
            errors++;
            $display("FAIL first_seg: got %h expected 3f", sg_a);
        end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_scan();
        int idx;
        for (int k = 0; k < 2 * W * DIV; k++) begin
            @(negedge clk);
            idx = ((cyc - 1) / DIV) % W;
            checks++;
            if (dg_a !== W'(1 << idx)) begin
                errors++;
                $display("FAIL scan_digit cyc%0d: got %b expected %b", cyc, dg_a, W'(1 << idx));
            end
            checks++;
            if (sg_a !== 7'h3F) begin
                errors++;
                $display("FAIL scan_seg cyc%0d: got %h expected 3f", cyc, sg_a);
            end
        end
        $display("test_scan done: errors=%0d", errors);
    endtask

    task automatic test_convert();
        int n;
        int v;
        start_load(1234, 1'b1);
        n = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_a) begin
                n = k;
                break;
            end
            checks++;
            if (sg_a !== 7'h3F) begin
                errors++;
                $display("FAIL hold_old k%0d: got %h expected 3f", k, sg_a);
            end
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len_1234: got %0d expected 15", n);
        end
        v = exp_q.pop_front();
        capture_scan();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_dig[i] !== W'(1 << i) || obs_seg[i] !== exp_seg(v, i, 1'b0)) begin
                errors++;
                $display("FAIL conv_%0d_d%0d: got dig=%b seg=%h expected dig=%b seg=%h",
                         v, i, obs_dig[i], obs_seg[i], W'(1 << i), exp_seg(v, i, 1'b0));
            end
        end
        $display("test_convert value=%0d errors=%0d", v, errors);
    endtask

    task automatic test_blank();
        int n;
        int v;
        blank_a = 1'b1;
        start_load(7, 1'b1);
        wait_idle(n);
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len_7: got %0d expected 15", n);
        end
        v = exp_q.pop_front();
        capture_scan();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg(v, i, 1'b1)) begin
                errors++;
                $display("FAIL blank_on_d%0d: got %h expected %h", i, obs_seg[i], exp_seg(v, i, 1'b1));
            end
        end
        blank_a = 1'b0;
        capture_scan();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg(v, i, 1'b0)) begin
                errors++;
                $display("FAIL blank_off_d%0d: got %h expected %h", i, obs_seg[i], exp_seg(v, i, 1'b0));
            end
        end
        $display("test_blank value=%0d errors=%0d", v, errors);
    endtask

    task automatic test_ovf();
        int n;
        int v;
        int vals [3] = '{10000, 42, 9999};
        logic bls [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            blank_a = bls[t];
            start_load(vals[t], 1'b1);
            for (int k = 0; k <= 16; k++) begin
                @(negedge clk);
                if (k == 15) begin
                    checks++;
                    if (ovf_a !== (vals[t] > 9999 ? 1'b0 : (t == 1))) begin
                        errors++;
                        $display("FAIL ovf_early_%0d: got %b expected previous flag", vals[t], ovf_a);
                    end
                end
            end
            checks++;
            if (ovf_a !== (vals[t] > 9999)) begin
                errors++;
                $display("FAIL ovf_flag_%0d: got %b expected %b", vals[t], ovf_a, vals[t] > 9999);
            end
            wait_idle(n);
            v = exp_q.pop_front();
            capture_scan();
            for (int i = 0; i < W; i++) begin
                checks++;
                if (obs_seg[i] !== exp_seg(v, i, bls[t])) begin
                    errors++;
                    $display("FAIL ovf_seq_%0d_d%0d: got %h expected %h", v, i, obs_seg[i], exp_seg(v, i, bls[t]));
                end
            end
            $display("test_ovf value=%0d blank=%b ovf=%b errors=%0d", v, bls[t], ovf_a, errors);
        end
        blank_a = 1'b0;
        capture_scan();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg(9999, i, 1'b0)) begin
                errors++;
                $display("FAIL ovf_9999_d%0d: got %h expected %h", i, obs_seg[i], exp_seg(9999, i, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int v;
        start_load(5, 1'b1);
        repeat (3) @(posedge clk);
        start_load(9, 1'b0);
        wait_idle(n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL ignored_load_busy: got %0d expected 11", n);
        end
        v = exp_q.pop_front();
        capture_scan();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg(v, i, 1'b0)) begin
                errors++;
                $display("FAIL ignored_load_d%0d: got %h expected %h", i, obs_seg[i], exp_seg(v, i, 1'b0));
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
        end
        $display("test_back_to_back value=%0d errors=%0d", v, errors);
    endtask

    task automatic test_reset_mid();
        start_load(1234, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_a, ovf_a, sg_a, dg_a} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b ovf=%b seg=%h dig=%b expected all 0", busy_a, ovf_a, sg_a, dg_a);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dg_a !== 4'b0001 || sg_a !== 7'h3F) begin
            errors++;
            $display("FAIL mid_reset_release: got dig=%b seg=%h expected 0001 3f", dg_a, sg_a);
        end
        capture_scan();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got busy=%b expected 0", busy_a);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_seg[i] !== 7'h3F) begin
                errors++;
                $display("FAIL mid_reset_d%0d: got %h expected 3f", i, obs_seg[i]);
            end
        end
        $display("test_reset_mid done: errors=%0d", errors);
    endtask

    task automatic test_div1();
        int old_v;
        int vals [3] = '{3, 12, 9};
        logic [6:0] es;
        blank_b = 1'b1;
        @(negedge clk);
        checks++;
        if (dg_b !== 1'b1 || sg_b !== 7'h3F) begin
            errors++;
            $display("FAIL div1_zero: got dig=%b seg=%h expected 1 3f", dg_b, sg_b);
        end
        old_v = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            value_b = 4'(vals[t]);
            load_b  = 1'b1;
            exp_q.push_back(vals[t]);
            @(posedge clk);
            #1;
            load_b = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                @(negedge clk);
                es = (k >= 7) ? exp_seg_b(exp_q[0]) : exp_seg_b(old_v);
                checks++;
                if (dg_b !== 1'b1 || sg_b !== es || busy_b !== (k <= 4)) begin
                    errors++;
                    $display("FAIL div1_%0d_k%0d: got dig=%b seg=%h busy=%b expected 1 %h %b",
                             vals[t], k, dg_b, sg_b, busy_b, es, k <= 4);
                end
            end
            checks++;
            if (ovf_b !== (exp_q[0] > 9)) begin
                errors++;
                $display("FAIL div1_ovf_%0d: got %b expected %b", vals[t], ovf_b, exp_q[0] > 9);
            end
            old_v = exp_q.pop_front();
            $display("test_div1 value=%0d seg=%h ovf=%b", old_v, sg_b, ovf_b);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_blank();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/drv_segment_dec_scan.md
Name: drv_segment_dec_scan

Overview:
Multiplexed decimal 7-segment display driver for p_width digits sharing one segment bus. It takes an unsigned binary value on a load strobe and converts it to BCD sequentially (double-dabble, one bit per clock). It then scans the digits with a programmable refresh prescaler. Optional leading-zero blanking and overflow indication are included. It sits between application counters/registers and the board's segment/digit-select pins.

Parameters:
p_width, 4, number of digits (1..8)
p_bin_width, 14, width of binary input (1..27)
p_div, 50000, clock cycles each digit stays selected (>=1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_value  input  p_bin_width  unsigned binary value to display
i_load  input  1  single-cycle strobe; captures i_value
i_blank_en  input  1  1 = blank leading zeros
o_busy  output  1  conversion in progress
o_ovf  output  1  displayed value exceeded 10^p_width-1
o_drv_sgmnt  output  7  segment pattern, bit n = segment n, active-high
o_drv_digit  output  p_width  one-hot digit select, bit 0 = least significant digit

Behaviour:
- Segment map: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
- Reset values:
  - o_drv_sgmnt = 0, o_drv_digit = 0, o_busy = 0, o_ovf = 0.
  - Display BCD register = 0, scan index = 0, prescaler = 0, FSM = IDLE.
- Conversion FSM IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: i_load=1 captures i_value; next state SHIFT; o_busy=1 from the next cycle.
  - SHIFT: exactly p_bin_width cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts left by one, inserting the binary MSB. The BCD scratch register is p_width+1 nibbles wide so overflow is detectable.
  - COMMIT: one cycle.
    - If the scratch value is > 10^p_width-1: o_ovf=1 and display register marked overflow.
    - Else: low p_width nibbles are copied to the display register and o_ovf=0.
    - o_busy=0 the following cycle.
- Timing: the display register updates p_bin_width+2 cycles after the i_load cycle.
- i_load while o_busy=1 is ignored (no queueing). The display keeps showing the previous committed value throughout conversion.
- Scan:
  - The prescaler counts 0..p_div-1 and wraps.
  - On wrap, the scan index increments and wraps from p_width-1 to 0.
  - p_div=1 advances the index every cycle.
- Outputs are registered, one cycle after index/display state:
  - o_drv_digit = one-hot(index).
  - o_drv_sgmnt = decode(display nibble[index]).
  - First valid output is the cycle after reset deasserts: digit 0 selected.
- Decode: 0..9 use standard patterns (0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F). Nibbles 10..15 cannot occur; they decode to blank (7'h00).
- Leading-zero blanking: with i_blank_en=1, digit i>0 is blank when digits i..p_width-1 are all 0. Digit 0 is never blanked, so value 0 shows a single "0". i_blank_en is sampled combinationally each scan cycle.
- Overflow display: every digit shows dash 7'h40. The overflow state persists until a subsequent in-range load commits.
- i_rst mid-conversion aborts conversion. The display returns to 0 and all reset values apply.

Decomposition:
- Package drv_segment_pkg holds:
  - the segment pattern constants (SEG_DIGIT[0:9], SEG_BLANK=7'h00, SEG_DASH=7'h40);
  - the BCD-to-segment decode function;
  - the FSM state enum (IDLE, SHIFT, COMMIT).
- Sub-module drv_segment_bin2bcd holds the sequential double-dabble converter (FSM + scratch register + overflow compare), with ports i_clk, i_rst, i_value, i_load, o_busy, o_done, o_bcd, o_ovf.
- Top-level holds the prescaler, scan index, blanking logic and output registers.

Test Plan:
- Reset then idle, p_div=4, p_width=4 -> o_drv_digit cycles 0001,0010,0100,1000, each held 4 cycles; o_drv_sgmnt=7'h3F on every digit with i_blank_en=0.
- Load 1234, p_bin_width=14 -> o_busy high 15 cycles; display updates at cycle 16; digit0=7'h66 (4), digit1=7'h4F (3), digit2=7'h5B (2), digit3=7'h06 (1).
- Load 7, i_blank_en=1 -> digit0=7'h07, digits1..3=7'h00; with i_blank_en=0 -> digits1..3=7'h3F.
- Load 10000 (>9999) -> o_ovf=1, all digits 7'h40; then load 42 -> o_ovf=0, digits show 0042 (or __42 with blanking).
- Load 5 then i_load=1 with 9 during o_busy -> second load ignored, final display 5; assert i_rst mid-SHIFT -> outputs zero, next cycle digit0 shows 7'h3F.
- p_div=1, p_width=1 -> o_drv_digit held at 1, segment output follows display each cycle.
